// File: rtl/ldpc_pkg.sv
// Shared constants, read-side state encoding and the LLR saturation rule
// for the LDPC input staging logic.
package ldpc_pkg;

  localparam int GRP_LEN = 36;
  localparam int D_WID   = 6;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_e;

  // Symmetric clamp to +/-(2^(d_wid-1)-1); the most negative code is never produced.
  function automatic int sat_llr(input int val, input int d_wid);
    int lim;
    lim = (1 << (d_wid - 1)) - 1;
    if (val > lim) begin
      return lim;
    end
    if (val < -lim) begin
      return -lim;
    end
    return val;
  endfunction

endpackage

// File: rtl/ldpc_llr_sat.sv
// Combinational I_WID -> D_WID symmetric LLR saturator.
module ldpc_llr_sat #(
  parameter int I_WID = 8,
  parameter int D_WID = ldpc_pkg::D_WID
) (
  input  logic signed [I_WID-1:0] llr_in,
  output logic signed [D_WID-1:0] llr_out
);
  import ldpc_pkg::*;

  assign llr_out = D_WID'(sat_llr(int'(llr_in), D_WID));

endmodule

// File: rtl/ldpc_llr_burst.sv
// Channel LLR input stage: saturates, gathers 36-symbol groups in a ping-pong
// buffer and replays each group as an unbroken burst for the VTC loader.
module ldpc_llr_burst #(
  parameter int I_WID   = 8,
  parameter int D_WID   = ldpc_pkg::D_WID,
  parameter int GRP_LEN = ldpc_pkg::GRP_LEN,
  parameter int FRM_GRP = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [I_WID-1:0] in_llr,
  input  logic                    in_valid,
  input  logic                    in_sof,
  output logic                    in_ready,
  input  logic                    load_en,
  output logic signed [D_WID-1:0] data_out,
  output logic                    sync_out,
  output logic                    frm_done,
  output logic                    sof_err
);
  import ldpc_pkg::*;

  localparam int CNT_W = $clog2(GRP_LEN);
  localparam int GRP_W = (FRM_GRP > 1) ? $clog2(FRM_GRP) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GRP_LEN - 1);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(FRM_GRP - 1);

  logic signed [D_WID-1:0] sat_val;

  logic signed [D_WID-1:0] bank_q [2][GRP_LEN];
  logic signed [D_WID-1:0] bank_d [2][GRP_LEN];
  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  rd_state_e               rd_state_q, rd_state_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [GRP_W-1:0]        rd_grp_q, rd_grp_d;
  logic signed [D_WID-1:0] data_out_q, data_out_d;
  logic                    sync_out_q, sync_out_d;
  logic                    frm_done_q, frm_done_d;
  logic                    sof_err_q, sof_err_d;
  logic                    accept;

  ldpc_llr_sat #(
    .I_WID(I_WID),
    .D_WID(D_WID)
  ) u_sat (
    .llr_in (in_llr),
    .llr_out(sat_val)
  );

  assign in_ready = !full_q[wr_bank_q] && !reset;
  assign accept   = in_valid && in_ready;

  // Write and read sides share full_d; they never touch the same bank's flag in one cycle.
  always_comb begin
    bank_d     = bank_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    wr_cnt_d   = wr_cnt_q;
    sof_err_d  = 1'b0;
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    rd_grp_d   = rd_grp_q;
    data_out_d = data_out_q;
    sync_out_d = 1'b0;
    frm_done_d = 1'b0;

    if (accept) begin
      if (in_sof && (wr_cnt_q != '0)) begin
        // Restart the group: the SOF symbol overwrites slot 0 of the same bank.
        bank_d[wr_bank_q][0] = sat_val;
        wr_cnt_d             = CNT_W'(1);
        sof_err_d            = 1'b1;
      end else begin
        bank_d[wr_bank_q][wr_cnt_q] = sat_val;
        if (wr_cnt_q == LAST_CNT) begin
          full_d[wr_bank_q] = 1'b1;
          wr_cnt_d          = '0;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
    end

    case (rd_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q] && load_en) begin
          rd_state_d = R_BURST;
        end
      end
      R_BURST: begin
        data_out_d = bank_q[rd_bank_q][rd_cnt_q];
        sync_out_d = 1'b1;
        if (rd_cnt_q == LAST_CNT) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_cnt_d          = '0;
          rd_grp_d          = (rd_grp_q == LAST_GRP) ? '0 : rd_grp_q + 1'b1;
          frm_done_d        = (rd_grp_q == LAST_GRP);
          rd_state_d        = (full_q[~rd_bank_q] && load_en) ? R_BURST : R_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      sof_err_q  <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      rd_grp_q   <= '0;
      data_out_q <= '0;
      sync_out_q <= 1'b0;
      frm_done_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      sof_err_q  <= sof_err_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_grp_q   <= rd_grp_d;
      data_out_q <= data_out_d;
      sync_out_q <= sync_out_d;
      frm_done_q <= frm_done_d;
    end
  end

  // Buffer contents need no reset; the cleared full flags make them stale.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign data_out = data_out_q;
  assign sync_out = sync_out_q;
  assign frm_done = frm_done_q;
  assign sof_err  = sof_err_q;

endmodule

// File: tb/tb_ldpc_llr_burst.sv
// Randomised and directed bench for ldpc_llr_burst, checked against a queue-based
// model of groups, bursts, frame boundaries and buffer occupancy.
module tb_ldpc_llr_burst;

  localparam int I_WID   = 8;
  localparam int D_WID   = 6;
  localparam int GRP_LEN = 36;
  localparam int FRM_GRP = 16;
  localparam int FRM_LEN = GRP_LEN * FRM_GRP;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic signed [I_WID-1:0] in_llr = '0;
  logic                    in_valid = 1'b0;
  logic                    in_sof = 1'b0;
  logic                    in_ready;
  logic                    load_en = 1'b0;
  logic signed [D_WID-1:0] data_out;
  logic                    sync_out;
  logic                    frm_done;
  logic                    sof_err;

  ldpc_llr_burst #(
    .I_WID(I_WID), .D_WID(D_WID), .GRP_LEN(GRP_LEN), .FRM_GRP(FRM_GRP)
  ) dut (
    .clk(clk), .reset(reset), .in_llr(in_llr), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .load_en(load_en), .data_out(data_out), .sync_out(sync_out),
    .frm_done(frm_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Model state: partial group, symbols awaiting replay, occupancy counts.
  int pend_q[$];
  int exp_q[$];
  int grp_done = 0, grp_out = 0, out_since_rst = 0, exp_sof_cyc = -1;
  int last_data = 0;
  bit rst_pending = 1'b1;
  bit prev_sync = 1'b0;

  // Per-test observations.
  int obs_q[$];
  int run_start_q[$], run_len_q[$], acc_grp_cyc_q[$];
  int run_start = 0, frm_cnt = 0, frm_cyc = 0, sof_cnt = 0, stall_cnt = 0;

  function automatic int satRef(input int v);
    int lim = 2 ** (D_WID - 1) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Outputs registered at the last posedge are judged at the following negedge;
  // a handshake seen here will be taken at the coming posedge (cycle cyc+1).
  always @(negedge clk) begin
    if (rst_pending) begin
      checkOutput("rst_data_out", int'(data_out), 0);
      checkOutput("rst_sync_out", int'(sync_out), 0);
      checkOutput("rst_frm_done", int'(frm_done), 0);
      checkOutput("rst_sof_err", int'(sof_err), 0);
      last_data = 0;
      prev_sync = 1'b0;
    end else begin
      if (sync_out) begin
        obs_q.push_back(int'(data_out));
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_sync", 1, 0);
        end else begin
          last_data = exp_q.pop_front();
          checkOutput("burst_data", int'(data_out), last_data);
        end
        out_since_rst++;
        if (out_since_rst % GRP_LEN == 0) grp_out++;
        checkOutput("frm_done", int'(frm_done), (out_since_rst % FRM_LEN == 0) ? 1 : 0);
      end else begin
        checkOutput("hold_data_out", int'(data_out), last_data);
        checkOutput("frm_done_idle", int'(frm_done), 0);
      end
      checkOutput("sof_err", int'(sof_err), (cyc == exp_sof_cyc) ? 1 : 0);
      if (frm_done) begin
        frm_cnt++;
        frm_cyc = cyc;
      end
      if (sof_err) sof_cnt++;
      if (sync_out && !prev_sync) run_start = cyc;
      if (!sync_out && prev_sync) begin
        run_start_q.push_back(run_start);
        run_len_q.push_back(cyc - run_start);
      end
      prev_sync = sync_out;
    end

    if (reset) begin
      checkOutput("ready_in_reset", int'(in_ready), 0);
      pend_q.delete();
      exp_q.delete();
      grp_done = 0;
      grp_out = 0;
      out_since_rst = 0;
      exp_sof_cyc = -1;
      rst_pending = 1'b1;
    end else begin
      rst_pending = 1'b0;
      checkOutput("in_ready", int'(in_ready), ((grp_done - grp_out) < 2) ? 1 : 0);
      if (in_valid && in_ready) begin
        if (in_sof && pend_q.size() != 0) begin
          pend_q.delete();
          exp_sof_cyc = cyc + 1;
        end
        pend_q.push_back(satRef(int'(in_llr)));
        if (pend_q.size() == GRP_LEN) begin
          foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
          pend_q.delete();
          grp_done++;
          acc_grp_cyc_q.push_back(cyc + 1);
        end
      end
    end
  end

  task automatic clearStats();
    obs_q.delete();
    run_start_q.delete();
    run_len_q.delete();
    acc_grp_cyc_q.delete();
    frm_cnt = 0;
    sof_cnt = 0;
    stall_cnt = 0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    in_sof = 1'b0;
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    clearStats();
  endtask

  // Offer one symbol and hold it until the handshake completes (bounded).
  task automatic applyStimulus(input int val, input bit sof);
    bit ok;
    int waited = 0;
    in_llr = I_WID'(val);
    in_sof = sof;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) stall_cnt++;
      waited++;
    end while (!ok && waited < 300);
    if (!ok) checkOutput("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  int sat_in [6] = '{100, -128, -5, 31, -32, 0};
  int sat_exp [6] = '{31, -31, -5, 31, -31, 0};

  initial begin
    int c, rdy_cyc, last;
    bit found;

    $display("[TB] saturation group");
    doReset();
    load_en = 1'b1;
    for (int i = 0; i < GRP_LEN; i++) applyStimulus((i < 6) ? sat_in[i] : 0, 1'b0);
    waitCycles(50);
    checkOutput("sat_runs", run_start_q.size(), 1);
    if (run_start_q.size() > 0 && acc_grp_cyc_q.size() > 0) begin
      checkOutput("sat_latency", run_start_q[0] - acc_grp_cyc_q[0], 2);
      checkOutput("sat_len", run_len_q[0], GRP_LEN);
    end
    checkOutput("sat_count", obs_q.size(), GRP_LEN);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) checkOutput("sat_value", obs_q[i], sat_exp[i]);

    $display("[TB] back-to-back groups");
    doReset();
    load_en = 1'b1;
    for (int i = 0; i < 2 * GRP_LEN; i++) applyStimulus(i, 1'b0);
    waitCycles(90);
    checkOutput("b2b_runs", run_start_q.size(), 1);
    if (run_start_q.size() > 0 && acc_grp_cyc_q.size() > 0) begin
      checkOutput("b2b_latency", run_start_q[0] - acc_grp_cyc_q[0], 2);
      checkOutput("b2b_len", run_len_q[0], 2 * GRP_LEN);
    end
    checkOutput("b2b_stalls", stall_cnt, 0);

    $display("[TB] backpressure");
    doReset();
    load_en = 1'b0;
    for (int i = 0; i < 2 * GRP_LEN; i++) applyStimulus(int'($urandom_range(0, 255)), 1'b0);
    waitCycles(3);
    @(negedge clk);
    checkOutput("bp_ready_low", int'(in_ready), 0);
    checkOutput("bp_no_burst", obs_q.size(), 0);
    @(posedge clk);
    #1;
    load_en = 1'b1;
    c = cyc;
    found = 1'b0;
    rdy_cyc = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (in_ready) begin
        found = 1'b1;
        rdy_cyc = cyc;
      end
    end
    checkOutput("bp_ready_back", int'(found), 1);
    waitCycles(90);
    checkOutput("bp_runs", run_start_q.size(), 1);
    if (run_start_q.size() > 0) begin
      checkOutput("bp_start", run_start_q[0], c + 2);
      checkOutput("bp_len", run_len_q[0], 2 * GRP_LEN);
      checkOutput("bp_ready_cycle", rdy_cyc, run_start_q[0] + GRP_LEN - 1);
    end

    $display("[TB] full frame");
    doReset();
    load_en = 1'b1;
    for (int i = 0; i < FRM_LEN; i++) applyStimulus(int'($urandom_range(0, 255)) - 128, i == 0);
    waitCycles(60);
    checkOutput("frm_symbols", obs_q.size(), FRM_LEN);
    checkOutput("frm_pulses", frm_cnt, 1);
    if (run_start_q.size() > 0) begin
      last = run_start_q.size() - 1;
      checkOutput("frm_position", frm_cyc, run_start_q[last] + run_len_q[last] - 1);
    end

    $display("[TB] SOF inside a group");
    doReset();
    load_en = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(int'($urandom_range(0, 255)), i == 0);
    for (int i = 0; i < GRP_LEN; i++) applyStimulus(int'($urandom_range(0, 255)), i == 0);
    waitCycles(60);
    checkOutput("sof_err_pulses", sof_cnt, 1);
    checkOutput("sof_runs", run_start_q.size(), 1);
    checkOutput("sof_symbols", obs_q.size(), GRP_LEN);

    $display("[TB] reset inside a burst");
    doReset();
    load_en = 1'b1;
    for (int i = 0; i < GRP_LEN; i++) applyStimulus(int'($urandom_range(0, 255)), 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (sync_out) found = 1'b1;
    end
    checkOutput("rst_burst_started", int'(found), 1);
    waitCycles(20);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    clearStats();
    waitCycles(60);
    checkOutput("rst_no_stale_burst", obs_q.size(), 0);
    @(negedge clk);
    checkOutput("rst_ready_after", int'(in_ready), 1);

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      load_en = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 4) != 0);
      in_llr = I_WID'($urandom_range(0, 255));
      in_sof = ($urandom_range(0, 59) == 0);
      waitCycles(1);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    load_en = 1'b1;
    waitCycles(150);
    checkOutput("rand_drained", exp_q.size(), 0);
    checkOutput("rand_bursts_seen", (obs_q.size() > 0) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
